// File: rtl/usb_rx_bit_timer.sv
// USB 1.1 receive bit timer. It resynchronises the bit phase on every D+ edge,
// NRZI-decodes the line and drops stuffed bits before they reach the byte shift register.
module usb_rx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SAMPLE_POINT = 3,
    parameter int unsigned STUFF_LEN    = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    input  logic enable,
    output logic serial_out,
    output logic shift_strobe,
    output logic byte_received,
    output logic eop,
    output logic stuff_err
);
    localparam int unsigned PHASE_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned ONES_W  = $clog2(STUFF_LEN + 1);
    localparam int unsigned BIT_W   = 3;

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               last_dp_q, last_dp_d;
    logic               prev_level_q, prev_level_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ONES_W-1:0]  ones_cnt_q, ones_cnt_d;
    logic               serial_out_q, serial_out_d;
    logic               shift_strobe_q, shift_strobe_d;
    logic               byte_pend_q, byte_pend_d;
    logic               byte_received_q, byte_received_d;
    logic               eop_q, eop_d;
    logic               stuff_err_q, stuff_err_d;

    logic line_edge_c;
    logic sample_c;
    logic se0_c;
    logic bit_val_c;

    assign line_edge_c = d_plus_sync != last_dp_q;
    assign sample_c    = phase_q == PHASE_W'(SAMPLE_POINT);
    assign se0_c       = !d_plus_sync && !d_minus_sync;
    assign bit_val_c   = d_plus_sync == prev_level_q;

    // Phase tracking, sampling decode and the sync clear while receive is idle.
    always_comb begin
        phase_d         = (phase_q == PHASE_W'(CLKS_PER_BIT - 1)) ? '0 : phase_q + PHASE_W'(1);
        last_dp_d       = d_plus_sync;
        prev_level_d    = prev_level_q;
        bit_cnt_d       = bit_cnt_q;
        ones_cnt_d      = ones_cnt_q;
        serial_out_d    = serial_out_q;
        shift_strobe_d  = 1'b0;
        byte_pend_d     = 1'b0;
        byte_received_d = byte_pend_q;
        eop_d           = 1'b0;
        stuff_err_d     = 1'b0;

        if (line_edge_c) begin
            phase_d = PHASE_W'(1);
        end

        if (sample_c) begin
            if (se0_c) begin
                eop_d      = 1'b1;
                bit_cnt_d  = '0;
                ones_cnt_d = '0;
            end else begin
                prev_level_d = d_plus_sync;
                if (ones_cnt_q == ONES_W'(STUFF_LEN)) begin
                    // The bit after a full run of ones is a stuffed 0, or a 1 that breaks the stuffing rule.
                    ones_cnt_d  = '0;
                    stuff_err_d = bit_val_c;
                end else begin
                    shift_strobe_d = 1'b1;
                    serial_out_d   = bit_val_c;
                    ones_cnt_d     = bit_val_c ? ones_cnt_q + ONES_W'(1) : '0;
                    bit_cnt_d      = bit_cnt_q + BIT_W'(1);
                    byte_pend_d    = bit_cnt_q == BIT_W'(7);
                end
            end
        end

        if (!enable) begin
            phase_d         = '0;
            last_dp_d       = 1'b1;
            prev_level_d    = 1'b1;
            bit_cnt_d       = '0;
            ones_cnt_d      = '0;
            serial_out_d    = 1'b1;
            shift_strobe_d  = 1'b0;
            byte_pend_d     = 1'b0;
            byte_received_d = 1'b0;
            eop_d           = 1'b0;
            stuff_err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_q         <= '0;
            last_dp_q       <= 1'b1;
            prev_level_q    <= 1'b1;
            bit_cnt_q       <= '0;
            ones_cnt_q      <= '0;
            serial_out_q    <= 1'b1;
            shift_strobe_q  <= 1'b0;
            byte_pend_q     <= 1'b0;
            byte_received_q <= 1'b0;
            eop_q           <= 1'b0;
            stuff_err_q     <= 1'b0;
        end else begin
            phase_q         <= phase_d;
            last_dp_q       <= last_dp_d;
            prev_level_q    <= prev_level_d;
            bit_cnt_q       <= bit_cnt_d;
            ones_cnt_q      <= ones_cnt_d;
            serial_out_q    <= serial_out_d;
            shift_strobe_q  <= shift_strobe_d;
            byte_pend_q     <= byte_pend_d;
            byte_received_q <= byte_received_d;
            eop_q           <= eop_d;
            stuff_err_q     <= stuff_err_d;
        end
    end

    assign serial_out    = serial_out_q;
    assign shift_strobe  = shift_strobe_q;
    assign byte_received = byte_received_q;
    assign eop           = eop_q;
    assign stuff_err     = stuff_err_q;

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// Bench for usb_rx_bit_timer. It builds the line as a list of timed cells and predicts
// every output cycle from the sampling/decoding rules.
module tb_usb_rx_bit_timer;
    localparam int CPB  = 8;
    localparam int SP   = 3;
    localparam int SL   = 6;
    localparam int MAXC = 2048;

    logic clk = 1'b0;
    logic n_rst;
    logic d_plus_sync;
    logic d_minus_sync;
    logic enable;
    logic serial_out;
    logic shift_strobe;
    logic byte_received;
    logic eop;
    logic stuff_err;

    int checks = 0;
    int errors = 0;

    // line description: cells of (D+, D-, length in clocks)
    logic sym_dp[$];
    logic sym_dm[$];
    int   sym_len[$];
    logic cur_lvl;
    int   enc_ones;

    logic cdp[MAXC];
    logic cdm[MAXC];
    int   ncyc;

    logic e_stb[MAXC+2];
    logic e_bit[MAXC+2];
    logic e_eop[MAXC+2];
    logic e_serr[MAXC+2];
    logic e_byte[MAXC+2];
    logic e_so[MAXC+2];

    logic cap_bits[$];
    int   stb_cyc[$];
    int   byte_cyc[$];
    int   cnt_eop;
    int   cnt_serr;

    usb_rx_bit_timer #(
        .CLKS_PER_BIT(CPB),
        .SAMPLE_POINT(SP),
        .STUFF_LEN   (SL)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus_sync  (d_plus_sync),
        .d_minus_sync (d_minus_sync),
        .enable       (enable),
        .serial_out   (serial_out),
        .shift_strobe (shift_strobe),
        .byte_received(byte_received),
        .eop          (eop),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

    task automatic clear_seq();
        sym_dp.delete();
        sym_dm.delete();
        sym_len.delete();
        cur_lvl  = 1'b1;
        enc_ones = 0;
    endtask

    task automatic add_cell(input logic dp, input logic dm, input int len);
        sym_dp.push_back(dp);
        sym_dm.push_back(dm);
        sym_len.push_back(len);
    endtask

    // NRZI: a decoded 0 toggles the line, a 1 holds it
    task automatic add_bit(input logic b, input int len);
        if (!b) cur_lvl = ~cur_lvl;
        add_cell(cur_lvl, ~cur_lvl, len);
        enc_ones = b ? enc_ones + 1 : 0;
    endtask

    task automatic send_bit(input logic b, input int len, input bit stuff);
        add_bit(b, len);
        if (stuff && enc_ones == SL) add_bit(1'b0, CPB);
    endtask

    task automatic add_se0(input int len);
        add_cell(1'b0, 1'b0, len);
        enc_ones = 0;
    endtask

    task automatic add_sync();
        for (int i = 0; i < 7; i++) add_bit(1'b0, CPB);
        add_bit(1'b1, CPB);
    endtask

    // Expand cells to cycles and predict every output from the receive rules.
    task automatic build_model();
        int   last_edge;
        logic pdp;
        logic lvl;
        int   ones;
        int   bits;
        logic b;
        bit   samp;
        ncyc = 0;
        foreach (sym_len[i]) begin
            for (int j = 0; j < sym_len[i]; j++) begin
                cdp[ncyc] = sym_dp[i];
                cdm[ncyc] = sym_dm[i];
                ncyc++;
            end
        end
        for (int j = 0; j < ncyc + 2; j++) begin
            e_stb[j] = 1'b0; e_bit[j] = 1'b0; e_eop[j] = 1'b0;
            e_serr[j] = 1'b0; e_byte[j] = 1'b0; e_so[j] = 1'b1;
        end
        last_edge = 0; pdp = 1'b1; lvl = 1'b1; ones = 0; bits = 0;
        for (int k = 0; k < ncyc; k++) begin
            samp = ((k - last_edge) % CPB) == SP;
            if (cdp[k] != pdp) last_edge = k;
            pdp = cdp[k];
            if (samp) begin
                if (!cdp[k] && !cdm[k]) begin
                    e_eop[k+1] = 1'b1;
                    bits = 0;
                    ones = 0;
                end else begin
                    b   = (cdp[k] == lvl);
                    lvl = cdp[k];
                    if (ones == SL) begin
                        e_serr[k+1] = b;
                        ones = 0;
                    end else begin
                        e_stb[k+1] = 1'b1;
                        e_bit[k+1] = b;
                        ones = b ? ones + 1 : 0;
                        bits++;
                        if (bits == 8) begin
                            bits = 0;
                            e_byte[k+2] = 1'b1;
                        end
                    end
                end
            end
        end
        for (int j = 1; j <= ncyc; j++) e_so[j] = e_stb[j] ? e_bit[j] : e_so[j-1];
    endtask

    // Drive the built line with enable high and compare every cycle to the model.
    task automatic run_seq(input string name, input bit rst_end);
        build_model();
        cap_bits.delete(); stb_cyc.delete(); byte_cyc.delete();
        cnt_eop = 0; cnt_serr = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            d_plus_sync  = cdp[k];
            d_minus_sync = cdm[k];
            enable       = 1'b1;
            @(posedge clk); #1;
            checks += 5;
            if (serial_out !== e_so[k+1]) begin
                errors++; $display("FAIL %s serial_out cyc=%0d got=%b exp=%b", name, k, serial_out, e_so[k+1]);
            end
            if (shift_strobe !== e_stb[k+1]) begin
                errors++; $display("FAIL %s shift_strobe cyc=%0d got=%b exp=%b", name, k, shift_strobe, e_stb[k+1]);
            end
            if (eop !== e_eop[k+1]) begin
                errors++; $display("FAIL %s eop cyc=%0d got=%b exp=%b", name, k, eop, e_eop[k+1]);
            end
            if (stuff_err !== e_serr[k+1]) begin
                errors++; $display("FAIL %s stuff_err cyc=%0d got=%b exp=%b", name, k, stuff_err, e_serr[k+1]);
            end
            if (byte_received !== e_byte[k+1]) begin
                errors++; $display("FAIL %s byte_received cyc=%0d got=%b exp=%b", name, k, byte_received, e_byte[k+1]);
            end
            if (shift_strobe === 1'b1) begin
                cap_bits.push_back(serial_out);
                stb_cyc.push_back(k);
            end
            if (byte_received === 1'b1) byte_cyc.push_back(k);
            if (eop === 1'b1) cnt_eop++;
            if (stuff_err === 1'b1) cnt_serr++;
        end
        @(negedge clk);
        if (rst_end) begin
            n_rst = 1'b0;
            #1;
        end else begin
            enable = 1'b0; d_plus_sync = 1'b1; d_minus_sync = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if ({serial_out, shift_strobe, byte_received, eop, stuff_err} !== 5'b10000) begin
            errors++;
            $display("FAIL %s idle_outputs got=%b exp=10000", name,
                     {serial_out, shift_strobe, byte_received, eop, stuff_err});
        end
        @(posedge clk); #1;
        checks++;
        if ({serial_out, shift_strobe, byte_received, eop, stuff_err} !== 5'b10000) begin
            errors++;
            $display("FAIL %s idle_outputs_2 got=%b exp=10000", name,
                     {serial_out, shift_strobe, byte_received, eop, stuff_err});
        end
        @(negedge clk);
        enable = 1'b0; d_plus_sync = 1'b1; d_minus_sync = 1'b0; n_rst = 1'b1;
        @(posedge clk);
    endtask

    task automatic check_bits(input string name, input logic exp_bits[$]);
        checks++;
        if (cap_bits.size() != exp_bits.size()) begin
            errors++; $display("FAIL %s strobe_count got=%0d exp=%0d", name, cap_bits.size(), exp_bits.size());
        end else begin
            foreach (exp_bits[i]) begin
                checks++;
                if (cap_bits[i] !== exp_bits[i]) begin
                    errors++; $display("FAIL %s bit%0d got=%b exp=%b", name, i, cap_bits[i], exp_bits[i]);
                end
            end
        end
    endtask

    task automatic push_sync_bits(inout logic q[$]);
        for (int i = 0; i < 7; i++) q.push_back(1'b0);
        q.push_back(1'b1);
    endtask

    task automatic test_reset();
        n_rst = 1'b0; enable = 1'b0; d_plus_sync = 1'b1; d_minus_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({serial_out, shift_strobe, byte_received, eop, stuff_err} !== 5'b10000) begin
            errors++; $display("FAIL reset_values got=%b exp=10000", {serial_out, shift_strobe, byte_received, eop, stuff_err});
        end
        @(negedge clk) n_rst = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            d_plus_sync  = 1'($urandom_range(0, 1));
            d_minus_sync = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checks++;
            if ({serial_out, shift_strobe, byte_received, eop, stuff_err} !== 5'b10000) begin
                errors++; $display("FAIL disabled_quiet cyc=%0d got=%b exp=10000", i, {serial_out, shift_strobe, byte_received, eop, stuff_err});
            end
        end
        @(negedge clk);
        d_plus_sync = 1'b1; d_minus_sync = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_sync();
        logic exp_bits[$];
        clear_seq(); add_sync();
        run_seq("sync", 1'b0);
        push_sync_bits(exp_bits);
        check_bits("sync", exp_bits);
        checks++;
        if (byte_cyc.size() != 1 || stb_cyc.size() != 8) begin
            errors++; $display("FAIL sync_byte_count got=%0d exp=1", byte_cyc.size());
        end else begin
            checks++;
            if (byte_cyc[0] != stb_cyc[7] + 1) begin
                errors++; $display("FAIL sync_byte_timing got=%0d exp=%0d", byte_cyc[0], stb_cyc[7] + 1);
            end
        end
    endtask

    task automatic test_stuffing();
        logic exp_bits[$];
        clear_seq(); add_sync();
        send_bit(1'b0, CPB, 1'b1);
        for (int i = 0; i < 6; i++) send_bit(1'b1, CPB, 1'b1);
        send_bit(1'b0, CPB, 1'b1);
        run_seq("stuffing", 1'b0);
        push_sync_bits(exp_bits);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 6; i++) exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0);
        check_bits("stuffing", exp_bits);
        checks++;
        if (byte_cyc.size() != 2 || cnt_serr != 0) begin
            errors++; $display("FAIL stuffing_bytes got=%0d/%0d exp=2/0", byte_cyc.size(), cnt_serr);
        end
    endtask

    task automatic test_stuff_err();
        logic exp_bits[$];
        clear_seq(); add_sync();
        send_bit(1'b0, CPB, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b1, CPB, 1'b0);
        run_seq("stuff_err", 1'b0);
        push_sync_bits(exp_bits);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 6; i++) exp_bits.push_back(1'b1);
        check_bits("stuff_err", exp_bits);
        checks++;
        if (cnt_serr != 1 || byte_cyc.size() != 1) begin
            errors++; $display("FAIL stuff_err_count got=%0d/%0d exp=1/1", cnt_serr, byte_cyc.size());
        end
    endtask

    task automatic test_eop();
        logic exp_bits[$];
        logic b;
        clear_seq(); add_sync();
        push_sync_bits(exp_bits);
        for (int i = 0; i < 3; i++) begin
            b = 1'(i % 2);
            send_bit(b, CPB, 1'b1);
            exp_bits.push_back(b);
        end
        add_se0(2 * CPB);
        for (int i = 0; i < 8; i++) begin
            b = 1'($urandom_range(0, 1));
            send_bit(b, CPB, 1'b1);
            exp_bits.push_back(b);
        end
        run_seq("eop", 1'b0);
        check_bits("eop", exp_bits);
        checks++;
        if (cnt_eop != 2) begin
            errors++; $display("FAIL eop_count got=%0d exp=2", cnt_eop);
        end
        checks++;
        if (byte_cyc.size() != 2 || stb_cyc.size() != 19) begin
            errors++; $display("FAIL eop_fresh_byte got=%0d exp=2", byte_cyc.size());
        end else begin
            checks++;
            if (byte_cyc[1] != stb_cyc[18] + 1) begin
                errors++; $display("FAIL eop_byte_timing got=%0d exp=%0d", byte_cyc[1], stb_cyc[18] + 1);
            end
        end
    endtask

    task automatic test_jitter();
        logic exp_bits[$];
        int starts[3];
        clear_seq(); add_sync();
        send_bit(1'b0, CPB + 2, 1'b0);
        send_bit(1'b0, CPB, 1'b0);
        send_bit(1'b0, CPB - 2, 1'b0);
        send_bit(1'b1, CPB, 1'b0);
        send_bit(1'b0, CPB, 1'b0);
        send_bit(1'b1, CPB, 1'b0);
        starts[0] = 8 * CPB;
        starts[1] = starts[0] + CPB + 2;
        starts[2] = starts[1] + CPB;
        run_seq("jitter", 1'b0);
        push_sync_bits(exp_bits);
        exp_bits.push_back(1'b0); exp_bits.push_back(1'b0); exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1); exp_bits.push_back(1'b0); exp_bits.push_back(1'b1);
        check_bits("jitter", exp_bits);
        if (stb_cyc.size() == 14) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (stb_cyc[8+i] != starts[i] + SP) begin
                    errors++; $display("FAIL jitter_sample%0d got=%0d exp=%0d", i, stb_cyc[8+i], starts[i] + SP);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic exp_bits[$];
        clear_seq(); add_sync();
        send_bit(1'b0, CPB, 1'b0);
        send_bit(1'b1, CPB, 1'b0);
        send_bit(1'b0, CPB, 1'b0);
        send_bit(1'b0, SP + 1, 1'b0);
        run_seq("reset_mid", 1'b1);
        clear_seq(); add_sync();
        run_seq("after_reset", 1'b0);
        push_sync_bits(exp_bits);
        check_bits("after_reset", exp_bits);
        checks++;
        if (byte_cyc.size() != 1) begin
            errors++; $display("FAIL after_reset_bytes got=%0d exp=1", byte_cyc.size());
        end
    endtask

    task automatic test_random();
        int   r;
        int   n;
        logic b;
        for (int it = 0; it < 8; it++) begin
            clear_seq();
            if (it % 2 == 0) begin
                add_cell(1'b0, 1'b1, CPB);
                n = $urandom_range(15, 35);
                for (int i = 0; i < n; i++) begin
                    r = $urandom_range(0, 9);
                    if (r < 4)       add_cell(1'b0, 1'b1, $urandom_range(5, 11));
                    else if (r < 8)  add_cell(1'b1, 1'b0, $urandom_range(5, 11));
                    else if (r == 8) add_cell(1'b0, 1'b0, $urandom_range(5, 11));
                    else             add_cell(1'b1, 1'b1, $urandom_range(5, 11));
                end
            end else begin
                add_sync();
                n = $urandom_range(10, 30);
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 9) == 0) add_se0(CPB);
                    else begin
                        b = 1'($urandom_range(0, 1));
                        send_bit(b, $urandom_range(CPB - 1, CPB + 1), 1'b1);
                    end
                end
            end
            run_seq("random", 1'b0);
        end
    endtask

    initial begin
        n_rst = 1'b0; enable = 1'b0; d_plus_sync = 1'b1; d_minus_sync = 1'b0;
        test_reset();
        test_sync();
        test_stuffing();
        test_stuff_err();
        test_eop();
        test_jitter();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
